// File: rtl/usbf_sync_filter_pkg.sv
// Shared constants and elaboration-time helpers for the sync/filter block.
package usbf_sync_filter_pkg;

  // Smallest legal synchronizer depth; shallower chains give no metastability margin.
  localparam int unsigned MIN_STAGE = 2;

  // Filter counter width: clog2(filt_cyc+1), never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned filt_cyc);
    int unsigned w;
    w = $clog2(filt_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Parameter sanity: a chain shallower than MIN_STAGE is raised to MIN_STAGE.
  function automatic int unsigned stage_depth(input int unsigned stage);
    return (stage < MIN_STAGE) ? MIN_STAGE : stage;
  endfunction

  // Filter terminal count; FILT_CYC of 0 or 1 both mean "follow on the first differing cycle".
  function automatic int unsigned filt_last(input int unsigned filt_cyc);
    return (filt_cyc <= 1) ? 0 : filt_cyc - 1;
  endfunction

endpackage

// File: rtl/usbf_sync_filter_if.sv
// Level inputs, freeze control and conditioned outputs of the sync filter.
interface usbf_sync_filter_if
  import usbf_sync_filter_pkg::*;
#(
  parameter int unsigned DW = 1
) ();

  logic [DW-1:0] din;
  logic          hold;
  logic [DW-1:0] dout;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;
  logic          chg;

  modport master (output din, hold, input dout, rise, fall, chg);
  modport slave  (input din, hold, output dout, rise, fall, chg);

endinterface

// File: rtl/usbf_sync_filter_bit.sv
// One channel: level synchronizer, stability filter and rise/fall pulse flops.
module usbf_sync_filter_bit
  import usbf_sync_filter_pkg::*;
#(
  parameter int unsigned STAGE    = 2,
  parameter int unsigned FILT_CYC = 4,
  parameter logic        RST_VAL  = 1'b0
) (
  input  logic clk_d,
  input  logic rst,
  input  logic din,
  input  logic hold,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic evt_c
);

  localparam int unsigned SD   = stage_depth(STAGE);
  localparam int unsigned CW   = cnt_width(FILT_CYC);
  localparam int unsigned LAST = filt_last(FILT_CYC);

  logic [SD-1:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic          s;

  // Synchronizer chain; free-running, unaffected by hold.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      sync_q <= {SD{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SD-2:0], din};
    end
  end

  assign s = sync_q[SD-1];

  // The new value has persisted long enough: dout follows on this edge.
  assign evt_c = !hold && (s != dout) && (cnt_q == CW'(LAST));

  // Stability counter, filtered level and one-cycle event pulses.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      dout  <= RST_VAL;
      cnt_q <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!hold) begin
        if (s == dout) begin
          cnt_q <= '0;
        end else if (evt_c) begin
          dout  <= s;
          cnt_q <= '0;
          rise  <= s;
          fall  <= !s;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/usbf_sync_filter.sv
// Multi-channel input conditioner: per-bit sync + glitch filter + edge events.
module usbf_sync_filter
  import usbf_sync_filter_pkg::*;
#(
  parameter int unsigned   DW       = 1,
  parameter int unsigned   STAGE    = 2,
  parameter int unsigned   FILT_CYC = 4,
  parameter logic [DW-1:0] RST_VAL  = '0
) (
  input  logic               clk_d,
  input  logic               rst,
  usbf_sync_filter_if.slave  bus
);

  logic [DW-1:0] dout_w;
  logic [DW-1:0] rise_w;
  logic [DW-1:0] fall_w;
  logic [DW-1:0] evt_w;
  logic          chg_q;

  // One independent conditioner per channel.
  for (genvar i = 0; i < int'(DW); i++) begin : g_ch
    usbf_sync_filter_bit #(
      .STAGE    (STAGE),
      .FILT_CYC (FILT_CYC),
      .RST_VAL  (RST_VAL[i])
    ) u_bit (
      .clk_d (clk_d),
      .rst   (rst),
      .din   (bus.din[i]),
      .hold  (bus.hold),
      .dout  (dout_w[i]),
      .rise  (rise_w[i]),
      .fall  (fall_w[i]),
      .evt_c (evt_w[i])
    );
  end

  // Any-channel change flag, registered in step with the rise/fall flops.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= |evt_w;
    end
  end

  assign bus.dout = dout_w;
  assign bus.rise = rise_w;
  assign bus.fall = fall_w;
  assign bus.chg  = chg_q;

endmodule

// File: tb/tb_usbf_sync_filter.sv
// Self-checking bench: two configurations against a run-length reference model.
module tb_usbf_sync_filter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usbf_sync_filter_if #(.DW(2)) bus_a ();
  usbf_sync_filter_if #(.DW(2)) bus_b ();

  usbf_sync_filter #(.DW(2), .STAGE(2), .FILT_CYC(4), .RST_VAL(2'b00)) dut_a (
    .clk_d (clk),
    .rst   (rst),
    .bus   (bus_a)
  );

  usbf_sync_filter #(.DW(2), .STAGE(3), .FILT_CYC(0), .RST_VAL(2'b11)) dut_b (
    .clk_d (clk),
    .rst   (rst),
    .bus   (bus_b)
  );

  logic [6:0] act_a;
  logic [6:0] act_b;
  assign act_a = {bus_a.chg, bus_a.fall, bus_a.rise, bus_a.dout};
  assign act_b = {bus_b.chg, bus_b.fall, bus_b.rise, bus_b.dout};

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // Each input reaches the filter after m_stg edges (delay line); dout takes
  // the delayed value once it has differed for max(FILT_CYC,1) unheld cycles.
  int unsigned m_stg [2] = '{2, 3};
  int unsigned m_flt [2] = '{4, 0};
  logic [1:0]  m_rv  [2] = '{2'b00, 2'b11};

  logic mp    [2][2][4];
  logic mq    [2][2];
  int   mrun  [2][2];
  logic mrise [2][2];
  logic mfall [2][2];
  logic mchg  [2];

  task automatic model_step();
    logic [1:0] dv;
    logic       hv;
    logic       sv;
    int unsigned need;
    for (int d = 0; d < 2; d++) begin
      dv = (d == 0) ? bus_a.din : bus_b.din;
      hv = (d == 0) ? bus_a.hold : bus_b.hold;
      need = (m_flt[d] > 1) ? m_flt[d] : 1;
      mchg[d] = 1'b0;
      for (int c = 0; c < 2; c++) begin
        mrise[d][c] = 1'b0;
        mfall[d][c] = 1'b0;
        if (rst) begin
          for (int k = 0; k < 4; k++) mp[d][c][k] = m_rv[d][c];
          mq[d][c]   = m_rv[d][c];
          mrun[d][c] = 0;
        end else begin
          sv = mp[d][c][m_stg[d]-1];
          for (int k = 3; k > 0; k--) mp[d][c][k] = mp[d][c][k-1];
          mp[d][c][0] = dv[c];
          if (!hv) begin
            if (sv == mq[d][c]) begin
              mrun[d][c] = 0;
            end else begin
              mrun[d][c] = mrun[d][c] + 1;
              if (mrun[d][c] >= int'(need)) begin
                mq[d][c]    = sv;
                mrun[d][c]  = 0;
                mrise[d][c] = sv;
                mfall[d][c] = !sv;
                mchg[d]     = 1'b1;
              end
            end
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  function automatic logic [6:0] exp_vec(input int d);
    return {mchg[d], mfall[d][1], mfall[d][0], mrise[d][1], mrise[d][0], mq[d][1], mq[d][0]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus_a.din = 2'b00; bus_b.din = 2'b11;
    bus_a.hold = 1'b0; bus_b.hold = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    bus_a.din = 2'b11; bus_b.din = 2'b00;
    bus_a.hold = 1'b0; bus_b.hold = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_cmp++;
    if (act_a !== 7'b0000000) begin n_bad++; $display("FAIL reset_a: got %b want %b", act_a, 7'b0000000); end
    n_cmp++;
    if (act_b !== 7'b0000011) begin n_bad++; $display("FAIL reset_b: got %b want %b", act_b, 7'b0000011); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (act_a !== 7'b0000000) begin n_bad++; $display("FAIL post_release_a: got %b want %b", act_a, 7'b0000000); end
    n_cmp++;
    if (act_b !== 7'b0000011) begin n_bad++; $display("FAIL post_release_b: got %b want %b", act_b, 7'b0000011); end
  endtask

  task automatic test_latency();
    logic [6:0] ea, eb;
    do_reset();
    bus_a.din = 2'b01;
    bus_b.din = 2'b10;
    for (int e = 1; e <= 10; e++) begin
      tick();
      ea = {(e == 6), 2'b00, (e == 6) ? 2'b01 : 2'b00, (e >= 6) ? 2'b01 : 2'b00};
      eb = {(e == 4), (e == 4) ? 2'b01 : 2'b00, 2'b00, (e >= 4) ? 2'b10 : 2'b11};
      n_cmp++;
      if (act_a !== ea) begin n_bad++; $display("FAIL latency_a edge %0d: got %b want %b", e, act_a, ea); end
      n_cmp++;
      if (act_b !== eb) begin n_bad++; $display("FAIL latency_b edge %0d: got %b want %b", e, act_b, eb); end
      n_cmp++;
      if (act_a !== exp_vec(0)) begin n_bad++; $display("FAIL latency_model_a edge %0d: got %b want %b", e, act_a, exp_vec(0)); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus_a.din = 2'b01;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) bus_a.din = 2'b00;
      n_cmp++;
      if (act_a !== 7'b0000000) begin n_bad++; $display("FAIL glitch edge %0d: got %b want %b", e, act_a, 7'b0000000); end
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] ea;
    int chg_cnt;
    chg_cnt = 0;
    do_reset();
    bus_a.din = 2'b11;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (bus_a.chg === 1'b1) chg_cnt++;
      ea = {(e == 6), 2'b00, (e == 6) ? 2'b11 : 2'b00, (e >= 6) ? 2'b11 : 2'b00};
      n_cmp++;
      if (act_a !== ea) begin n_bad++; $display("FAIL simultaneous edge %0d: got %b want %b", e, act_a, ea); end
    end
    n_cmp++;
    if (chg_cnt !== 1) begin n_bad++; $display("FAIL simultaneous_chg_cycles: got %0d want 1", chg_cnt); end
  endtask

  task automatic test_hold();
    logic [6:0] ea;
    do_reset();
    bus_a.din = 2'b01;
    for (int e = 1; e <= 20; e++) begin
      tick();
      ea = {(e == 16), 2'b00, (e == 16) ? 2'b01 : 2'b00, (e >= 16) ? 2'b01 : 2'b00};
      n_cmp++;
      if (act_a !== ea) begin n_bad++; $display("FAIL hold edge %0d: got %b want %b", e, act_a, ea); end
      if (e == 3)  bus_a.hold = 1'b1;
      if (e == 13) bus_a.hold = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] ea;
    do_reset();
    bus_a.din = 2'b01;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (act_a !== 7'b0000000) begin n_bad++; $display("FAIL reset_mid_a: got %b want %b", act_a, 7'b0000000); end
    n_cmp++;
    if (act_b !== 7'b0000011) begin n_bad++; $display("FAIL reset_mid_b: got %b want %b", act_b, 7'b0000011); end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      ea = {(e == 6), 2'b00, (e == 6) ? 2'b01 : 2'b00, (e >= 6) ? 2'b01 : 2'b00};
      n_cmp++;
      if (act_a !== ea) begin n_bad++; $display("FAIL reset_mid_release edge %0d: got %b want %b", e, act_a, ea); end
    end
  endtask

  task automatic test_random();
    int pulses;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 7) == 0) bus_a.din[c] = ~bus_a.din[c];
        if ($urandom_range(0, 3) == 0) bus_b.din[c] = ~bus_b.din[c];
      end
      if ($urandom_range(0, 15) == 0) bus_a.hold = ~bus_a.hold;
      if ($urandom_range(0, 15) == 0) bus_b.hold = ~bus_b.hold;
      tick();
      if (bus_a.chg === 1'b1) pulses++;
      n_cmp++;
      if (act_a !== exp_vec(0)) begin n_bad++; $display("FAIL random_a cycle %0d: got %b want %b", i, act_a, exp_vec(0)); end
      n_cmp++;
      if (act_b !== exp_vec(1)) begin n_bad++; $display("FAIL random_b cycle %0d: got %b want %b", i, act_b, exp_vec(1)); end
    end
    rst = 1'b0;
    n_cmp++;
    if (pulses == 0) begin n_bad++; $display("FAIL random_activity: got %0d change cycles want >0", pulses); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
